// File: rtl/csp_channel_pkg.sv
// Shared constants and packet type for the CSP channel: default flit width,
// destination-id field position and a flit builder used by producers.
package csp_channel_pkg;

  localparam int WIDTH_DEFAULT = 33;
  localparam int DEST_MSB      = 32;
  localparam int DEST_LSB      = 29;
  localparam int DEST_W        = DEST_MSB - DEST_LSB + 1;

  typedef logic [WIDTH_DEFAULT-1:0] packet_t;

  function automatic packet_t make_flit(input logic [DEST_W-1:0]   dest,
                                        input logic [DEST_LSB-1:0] payload);
    packet_t p;
    p = '0;
    p[DEST_MSB:DEST_LSB] = dest;
    p[DEST_LSB-1:0]      = payload;
    return p;
  endfunction

endpackage

// File: rtl/csp_channel_stats.sv
// Receive statistics for csp_channel: saturating completed-receive count and
// the clock distance between the two most recent completions.
module csp_channel_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r_req,
  input  logic             r_ack,
  output logic [CNT_W-1:0] xfer_count,
  output logic [CNT_W-1:0] cycle_time
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_ack_p0;
  logic             seen_first;
  logic [CNT_W-1:0] gap_cnt;
  logic             complete;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // A receive completes when r_ack moves and lands on r_req; a toggle while
  // the channel is empty leaves them unequal and is not counted.
  assign complete = (r_ack != r_ack_p0) && (r_ack == r_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack_p0   <= 1'b0;
      seen_first <= 1'b0;
      gap_cnt    <= '0;
      xfer_count <= '0;
      cycle_time <= '0;
    end else begin
      r_ack_p0 <= r_ack;
      if (complete) begin
        xfer_count <= sat_inc(xfer_count);
        seen_first <= 1'b1;
        gap_cnt    <= CNT_ONE;
        if (seen_first) begin
          cycle_time <= gap_cnt;
        end
      end else begin
        gap_cnt <= sat_inc(gap_cnt);
      end
    end
  end

endmodule

// File: rtl/csp_channel.sv
// Point-to-point CSP channel with 2-phase toggle handshakes and a one-entry
// holding register. Optional statistics enabled by CSP_CHANNEL_STATS_EN.
module csp_channel
  import csp_channel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  output logic             full
`ifdef CSP_CHANNEL_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count,
  output logic [CNT_W-1:0] cycle_time
`endif
);

  logic pending;
  logic empty;
  logic capture;

  // Emptiness uses the live r_ack so a same-cycle acknowledge frees the slot.
  assign pending = s_req ^ s_ack;
  assign empty   = ~(r_req ^ r_ack);
  assign capture = pending & empty;
  assign full    = r_req ^ r_ack;

  // Stage p0: holding register; both toggles flip together on capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ack  <= 1'b0;
      r_req  <= 1'b0;
      r_data <= '0;
    end else if (capture) begin
      s_ack  <= ~s_ack;
      r_req  <= ~r_req;
      r_data <= s_data;
    end
  end

`ifdef CSP_CHANNEL_STATS_EN
  csp_channel_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .reset     (reset),
    .r_req     (r_req),
    .r_ack     (r_ack),
    .xfer_count(xfer_count),
    .cycle_time(cycle_time)
  );
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_csp_channel.sv
// Scoreboard bench for csp_channel; stats checks compile in with CSP_CHANNEL_STATS_EN.
module tb_csp_channel;
  import csp_channel_pkg::*;

  localparam int WIDTH = WIDTH_DEFAULT;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_req;
  logic [WIDTH-1:0] s_data;
  logic             s_ack;
  logic             r_req;
  logic [WIDTH-1:0] r_data;
  logic             r_ack;
  logic             full;
`ifdef CSP_CHANNEL_STATS_EN
  logic [CNT_W-1:0] xfer_count;
  logic [CNT_W-1:0] cycle_time;
`endif

  int      n_tests = 0;
  int      n_fail  = 0;
  packet_t exp_q[$];
  packet_t exp_pkt;

  csp_channel #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_req (s_req),
    .s_data(s_data),
    .s_ack (s_ack),
    .r_req (r_req),
    .r_data(r_data),
    .r_ack (r_ack),
    .full  (full)
`ifdef CSP_CHANNEL_STATS_EN
    ,
    .xfer_count(xfer_count),
    .cycle_time(cycle_time)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    s_req  = 1'b0;
    r_ack  = 1'b0;
    s_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (s_ack !== 1'b0) begin n_fail++; $display("FAIL reset_s_ack: got %b want 0", s_ack); end
    n_tests++;
    if (r_req !== 1'b0) begin n_fail++; $display("FAIL reset_r_req: got %b want 0", r_req); end
    n_tests++;
    if (r_data !== '0) begin n_fail++; $display("FAIL reset_r_data: got %h want 0", r_data); end
    n_tests++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
  endtask

  task automatic test_transfer;
    s_data = 33'h1_2000_0000;
    exp_q.push_back(33'h1_2000_0000);
    s_req = ~s_req;
    tick();
    n_tests++;
    if (r_req !== 1'b1) begin n_fail++; $display("FAIL xfer_r_req: got %b want 1", r_req); end
    n_tests++;
    if (s_ack !== 1'b1) begin n_fail++; $display("FAIL xfer_s_ack: got %b want 1", s_ack); end
    n_tests++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL xfer_full: got %b want 1", full); end
    exp_pkt = exp_q.pop_front();
    n_tests++;
    if (r_data !== exp_pkt) begin n_fail++; $display("FAIL xfer_data: got %h want %h", r_data, exp_pkt); end
  endtask

  task automatic test_backpressure;
    packet_t first;
    first  = 33'h1_2000_0000;
    s_data = make_flit(4'd3, 29'h0ABC);
    exp_q.push_back(s_data);
    s_req = ~s_req;
    tick();
    tick();
    n_tests++;
    if (s_ack !== 1'b1) begin n_fail++; $display("FAIL bp_hold_s_ack: got %b want 1", s_ack); end
    n_tests++;
    if (r_data !== first) begin n_fail++; $display("FAIL bp_hold_data: got %h want %h", r_data, first); end
    r_ack = ~r_ack;
    tick();
    n_tests++;
    if (s_ack !== 1'b0) begin n_fail++; $display("FAIL bp_cap_s_ack: got %b want 0", s_ack); end
    n_tests++;
    if (r_req !== 1'b0) begin n_fail++; $display("FAIL bp_cap_r_req: got %b want 0", r_req); end
    exp_pkt = exp_q.pop_front();
    n_tests++;
    if (r_data !== exp_pkt) begin n_fail++; $display("FAIL bp_cap_data: got %h want %h", r_data, exp_pkt); end
    r_ack = ~r_ack;
    tick();
    n_tests++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL bp_drain_full: got %b want 0", full); end
  endtask

  task automatic test_back_to_back;
    logic prev_rreq;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) r_ack = ~r_ack;
      s_data = make_flit(4'(i), 29'(i * 7 + 1));
      exp_q.push_back(s_data);
      s_req     = ~s_req;
      prev_rreq = r_req;
      tick();
      n_tests++;
      if (r_req === prev_rreq) begin
        n_fail++;
        $display("FAIL b2b_stall: packet %0d r_req got %b want %b", i, r_req, ~prev_rreq);
      end else begin
        exp_pkt = exp_q.pop_front();
        if (r_data !== exp_pkt) begin
          n_fail++;
          $display("FAIL b2b_data: packet %0d got %h want %h", i, r_data, exp_pkt);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d queued want 0", exp_q.size()); end
    r_ack = ~r_ack;
    tick();
  endtask

  task automatic test_reset_mid;
    s_data = make_flit(4'd5, 29'h1);
    s_req  = ~s_req;
    tick();
    n_tests++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL mid_pre_full: got %b want 1", full); end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (s_ack !== 1'b0) begin n_fail++; $display("FAIL mid_s_ack: got %b want 0", s_ack); end
    n_tests++;
    if (r_req !== 1'b0) begin n_fail++; $display("FAIL mid_r_req: got %b want 0", r_req); end
    n_tests++;
    if (r_data !== '0) begin n_fail++; $display("FAIL mid_r_data: got %h want 0", r_data); end
    n_tests++;
    if (full !== r_ack) begin n_fail++; $display("FAIL mid_full: got %b want %b", full, r_ack); end
    s_req = 1'b0;
    r_ack = 1'b0;
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef CSP_CHANNEL_STATS_EN
  task automatic test_stats;
    n_tests++;
    if (xfer_count !== '0) begin n_fail++; $display("FAIL stats_reset_count: got %0d want 0", xfer_count); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) repeat (2) tick();
      s_data = make_flit(4'(k + 1), 29'(k));
      s_req  = ~s_req;
      tick();
      r_ack = ~r_ack;
      tick();
    end
    n_tests++;
    if (xfer_count !== 32'd3) begin n_fail++; $display("FAIL stats_count: got %0d want 3", xfer_count); end
    n_tests++;
    if (cycle_time !== 32'd4) begin n_fail++; $display("FAIL stats_cycle: got %0d want 4", cycle_time); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_transfer();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef CSP_CHANNEL_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
